// File: rtl/regfile_pkg.sv
// Shared widths and write-request type for the register file write arbiter.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regfile_wr_fifo.sv
// MDU result FIFO: strict order, power-of-two depth, all entries exposed with a valid mask.
module regfile_wr_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [ADDR_W-1:0]              push_addr,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
  output logic [ADDR_W-1:0]              head_addr,
  output logic [DATA_W-1:0]              head_data,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           full,
  output logic                           empty,
  output logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr,
  output logic [DEPTH-1:0]               entry_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
  logic [DEPTH-1:0][DATA_W-1:0] data_mem;
  logic [PW-1:0]                wr_ptr, rd_ptr;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign entry_addr = addr_mem;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [PW-1:0] off;
    assign off            = PW'(i) - rd_ptr;
    assign entry_valid[i] = ({1'b0, off} < count);
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between WB (always wins) and buffered MDU results.
// Optional macro REGFILE_ZERO_FILTER_EN suppresses writes to register 0.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int ADDR_W     = regfile_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wb_valid,
  input  logic [ADDR_W-1:0]            wb_reg,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic                         mdu_valid,
  output logic                         mdu_ready,
  input  logic [ADDR_W-1:0]            mdu_reg,
  input  logic [DATA_W-1:0]            mdu_data,
  output logic                         rf_reg_write,
  output logic [ADDR_W-1:0]            rf_write_reg,
  output logic [DATA_W-1:0]            rf_write_data,
  output logic                         wb_stall_req,
  output logic [2**ADDR_W-1:0]         mdu_pending,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                                  push, pop, full, empty;
  logic [ADDR_W-1:0]                     head_addr;
  logic [DATA_W-1:0]                     head_data;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0]     entry_addr;
  logic [FIFO_DEPTH-1:0]                 entry_valid;
  logic                                  grant;
  logic                                  grant_we;
  logic [ADDR_W-1:0]                     grant_reg;
  logic [DATA_W-1:0]                     grant_data;
  logic [SW-1:0]                         starve_cnt, starve_nxt;

  // Ready comes from registered occupancy only: a full FIFO never accepts, even while draining.
  assign mdu_ready = !full;
  assign push      = mdu_valid && mdu_ready;
  assign pop       = !wb_valid && !empty;

  regfile_wr_fifo #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_addr  (mdu_reg),
    .push_data  (mdu_data),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (fifo_count),
    .full       (full),
    .empty      (empty),
    .entry_addr (entry_addr),
    .entry_valid(entry_valid)
  );

  always_comb begin
    grant      = wb_valid || pop;
    grant_reg  = wb_valid ? wb_reg  : head_addr;
    grant_data = wb_valid ? wb_data : head_data;
`ifdef REGFILE_ZERO_FILTER_EN
    grant_we   = grant && (grant_reg != '0);
`else
    grant_we   = grant;
`endif
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || empty)
      starve_nxt = '0;
    else if (starve_cnt != SW'(STARVE_MAX))
      starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_reg_write  <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      starve_cnt    <= '0;
      wb_stall_req  <= 1'b0;
    end else begin
      rf_reg_write <= grant_we;
      if (grant) begin
        rf_write_reg  <= grant_reg;
        rf_write_data <= grant_data;
      end
      starve_cnt   <= starve_nxt;
      // Held until the starved head finally drains.
      wb_stall_req <= !pop && (wb_stall_req || (starve_nxt == SW'(STARVE_MAX)));
    end
  end

  always_comb begin
    mdu_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (entry_valid[i]) mdu_pending[entry_addr[i]] = 1'b1;
`ifdef REGFILE_ZERO_FILTER_EN
    mdu_pending[0] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus starvation and mid-stream reset sequences.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

`ifdef REGFILE_ZERO_FILTER_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wb_valid = 1'b0;
  logic [4:0]        wb_reg = '0;
  logic [31:0]       wb_data = '0;
  logic              mdu_valid = 1'b0;
  logic              mdu_ready;
  logic [4:0]        mdu_reg = '0;
  logic [31:0]       mdu_data = '0;
  logic              rf_reg_write;
  logic [4:0]        rf_write_reg;
  logic [31:0]       rf_write_data;
  logic              wb_stall_req;
  logic [31:0]       mdu_pending;
  logic [1:0]        fifo_count;

  int nvec  = 0;
  int nfail = 0;

  regfile_write_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .mdu_valid    (mdu_valid),
    .mdu_ready    (mdu_ready),
    .mdu_reg      (mdu_reg),
    .mdu_data     (mdu_data),
    .rf_reg_write (rf_reg_write),
    .rf_write_reg (rf_write_reg),
    .rf_write_data(rf_write_data),
    .wb_stall_req (wb_stall_req),
    .mdu_pending  (mdu_pending),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wbv;
    wr_req_t    wb;
    logic       mv;
    wr_req_t    md;
    logic       we;
    wr_req_t    rf;
    int         cnt;
    logic       rdy;
    logic [31:0] pend;
  } vec_t;

  vec_t v[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wbv, input wr_req_t wb, input logic mv, input wr_req_t md);
    wb_valid  = wbv;
    wb_reg    = wb.addr;
    wb_data   = wb.data;
    mdu_valid = mv;
    mdu_reg   = md.addr;
    mdu_data  = md.data;
  endtask

  task automatic check(input string name, input logic we, input logic [4:0] r, input logic [31:0] d,
                       input int cnt, input logic rdy, input logic [31:0] pend);
    nvec++;
    if (rf_reg_write !== we || rf_write_reg !== r || rf_write_data !== d ||
        int'(fifo_count) != cnt || mdu_ready !== rdy || mdu_pending !== pend) begin
      nfail++;
      $display("FAIL %s: got we=%0b reg=%0d data=%h cnt=%0d rdy=%0b pend=%h; want we=%0b reg=%0d data=%h cnt=%0d rdy=%0b pend=%h",
               name, rf_reg_write, rf_write_reg, rf_write_data, fifo_count, mdu_ready, mdu_pending,
               we, r, d, cnt, rdy, pend);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  function automatic wr_req_t rq(input logic [4:0] a, input logic [31:0] d);
    wr_req_t r;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  function automatic vec_t mk(input logic wbv, input wr_req_t wb, input logic mv, input wr_req_t md,
                              input logic we, input wr_req_t rf, input int cnt, input logic rdy,
                              input logic [31:0] pend);
    vec_t x;
    x.wbv = wbv; x.wb = wb; x.mv = mv; x.md = md;
    x.we = we; x.rf = rf; x.cnt = cnt; x.rdy = rdy; x.pend = pend;
    return x;
  endfunction

  initial begin
    wr_req_t z;
    z = rq(5'd0, 32'h0);
    // WB only, then MDU into idle WB
    v[0]  = mk(1, rq(8, 32'hDEADBEEF), 0, z, 1, rq(8, 32'hDEADBEEF), 0, 1, 32'h0);
    v[1]  = mk(0, z, 0, z,                    0, rq(8, 32'hDEADBEEF), 0, 1, 32'h0);
    v[2]  = mk(0, z, 1, rq(9, 32'h12345678),  0, rq(8, 32'hDEADBEEF), 1, 1, 32'h1 << 9);
    v[3]  = mk(0, z, 0, z,                    1, rq(9, 32'h12345678), 0, 1, 32'h0);
    v[4]  = mk(0, z, 0, z,                    0, rq(9, 32'h12345678), 0, 1, 32'h0);
    // Back-pressure while WB holds the port; third offer waits, retire order, pointer wrap
    v[5]  = mk(1, rq(1, 32'hA1), 1, rq(3, 32'h33), 1, rq(1, 32'hA1), 1, 1, 32'h8);
    v[6]  = mk(1, rq(2, 32'hA2), 1, rq(4, 32'h44), 1, rq(2, 32'hA2), 2, 0, 32'h18);
    v[7]  = mk(1, rq(5, 32'hA5), 1, rq(6, 32'h66), 1, rq(5, 32'hA5), 2, 0, 32'h18);
    v[8]  = mk(0, z, 1, rq(6, 32'h66),           1, rq(3, 32'h33), 1, 1, 32'h10);
    v[9]  = mk(0, z, 1, rq(6, 32'h66),           1, rq(4, 32'h44), 1, 1, 32'h40);
    v[10] = mk(0, z, 0, z,                       1, rq(6, 32'h66), 0, 1, 32'h0);
    v[11] = mk(0, z, 0, z,                       0, rq(6, 32'h66), 0, 1, 32'h0);
    // Register 0 handling from both producers
    v[12] = mk(1, rq(0, 32'h5), 0, z,            !ZF, rq(0, 32'h5), 0, 1, 32'h0);
    v[13] = mk(0, z, 0, z,                       0, rq(0, 32'h5), 0, 1, 32'h0);
    v[14] = mk(1, rq(7, 32'h70), 1, rq(0, 32'h77), 1, rq(7, 32'h70), 1, 1, ZF ? 32'h0 : 32'h1);
    v[15] = mk(0, z, 0, z,                       !ZF, rq(0, 32'h77), 0, 1, 32'h0);

    // Reset state
    #2;
    check("reset", 0, 0, 0, 0, 1, 32'h0);
    check1("reset_stall", wb_stall_req, 1'b0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(v[i].wbv, v[i].wb, v[i].mv, v[i].md);
      step();
      check($sformatf("vec%0d", i), v[i].we, v[i].rf.addr, v[i].rf.data, v[i].cnt, v[i].rdy, v[i].pend);
    end

    // Starvation: entry queued while WB is busy every cycle
    drive(1, rq(1, 32'h1), 1, rq(10, 32'hAA));
    step();
    check1("starve_push_stall", wb_stall_req, 1'b0);
    drive(1, rq(1, 32'h1), 0, z);
    for (int c = 1; c <= 3; c++) begin
      step();
      check1($sformatf("starve_cyc%0d", c), wb_stall_req, 1'b0);
    end
    step();
    check1("starve_cyc4", wb_stall_req, 1'b1);
    step();
    check1("starve_sat", wb_stall_req, 1'b1);
    drive(0, z, 0, z);
    step();
    check1("starve_release", wb_stall_req, 1'b0);
    check("starve_retire", 1, 10, 32'hAA, 0, 1, 32'h0);

    // Reset with two queued entries
    drive(1, rq(2, 32'h2), 1, rq(11, 32'hB1));
    step();
    drive(1, rq(2, 32'h2), 1, rq(12, 32'hB2));
    step();
    check("pre_reset_full", 1, 2, 32'h2, 2, 0, (32'h1 << 11) | (32'h1 << 12));
    drive(0, z, 0, z);
    rst_n = 1'b0;
    #1;
    check("mid_reset", 0, 0, 0, 0, 1, 32'h0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("post_reset%0d", c), 0, 0, 0, 0, 1, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single synchronous write port between two producers:
  - the pipeline writeback stage (WB), which can never be back-pressured;
  - the multi-cycle multiply/divide unit (MDU), which uses a valid/ready handshake.
- MDU results are buffered in a small FIFO and drained whenever WB is idle.
- A starvation counter requests a WB bubble from the hazard unit.
- Sits between the WB/MDU outputs and the register file write port (reg_write, write_reg, write_data).

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may be denied before a bubble is requested

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wb_valid  input  1  WB stage writes this cycle
- wb_reg  input  ADDR_W  WB destination register
- wb_data  input  DATA_W  WB result
- mdu_valid  input  1  MDU result offered
- mdu_ready  output  1  FIFO can accept
- mdu_reg  input  ADDR_W  MDU destination register
- mdu_data  input  DATA_W  MDU result
- rf_reg_write  output  1  to register file reg_write
- rf_write_reg  output  ADDR_W  to register file write_reg
- rf_write_data  output  DATA_W  to register file write_data
- wb_stall_req  output  1  request to hazard unit for a WB bubble
- mdu_pending  output  2**ADDR_W  bit r set while any FIFO entry targets register r
- fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync deassert by system):
  - rf_reg_write=0, rf_write_reg=0, rf_write_data=0
  - wb_stall_req=0, fifo_count=0, mdu_pending=0, starve counter=0
  - FIFO pointers=0
- All rf_* outputs are registered. Latency is exactly 1 cycle from grant to rf_reg_write.
- Enqueue:
  - MDU transfer occurs when mdu_valid && mdu_ready.
  - mdu_ready = (fifo_count != FIFO_DEPTH), derived from registered state only.
  - When full, mdu_ready=0 even if a dequeue happens in the same cycle (no pass-through).
- Grant, each cycle:
  - wb_valid=1: WB is granted; the next cycle drives rf_reg_write=1 with wb_reg/wb_data. The FIFO does not dequeue.
  - else if FIFO non-empty: the head is granted and dequeued; the next cycle drives its reg/data.
  - else: rf_reg_write=0 next cycle. rf_write_reg and rf_write_data hold their previous values.
- Simultaneous enqueue and dequeue (not full): both occur and fifo_count is unchanged. An entry enqueued in cycle N is eligible for grant no earlier than cycle N+1 (no bypass).
- FIFO order is strict FIFO. Pointers wrap modulo FIFO_DEPTH.
- Starvation counter:
  - Increments when the FIFO is non-empty and WB is granted.
  - Clears on any FIFO dequeue or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- wb_stall_req is registered:
  - Sets the cycle after the counter reaches STARVE_MAX.
  - Clears the cycle after the next FIFO dequeue.
- mdu_pending is combinational: the OR-decode of the reg fields of all valid FIFO entries. The hazard unit uses it to stall readers and WAW writers.
- Reset mid-operation: FIFO contents are discarded and no write is issued to the register file.

Optional Feature:
- Macro REGFILE_ZERO_FILTER_EN.
- Defined:
  - Any grant with destination register 0 produces rf_reg_write=0, but the grant still consumes the FIFO entry and resets the starve counter.
  - mdu_pending bit 0 is forced to 0.
- Undefined: register 0 writes pass through unchanged. Software and the hazard logic must avoid them.

Decomposition:
- Package regfile_pkg:
  - DATA_W and ADDR_W constants
  - a write-request struct type {reg, data}
  - the NUM_REGS constant (2**ADDR_W)
- Sub-module regfile_wr_fifo:
  - parameterized FIFO with push/pop, count and full/empty flags
  - exposes all entries, with a valid mask, for the mdu_pending decode
- Arbitration, starve counter and output registers live in the top module.

Test Plan:
- Reset mid-stream: FIFO holds 2 entries, assert rst_n=0 for 1 cycle → fifo_count=0, rf_reg_write=0, mdu_pending=0, and no write to the register file afterwards.
- WB only: wb_valid=1, wb_reg=8, wb_data=0xDEADBEEF in cycle N → rf_reg_write=1, rf_write_reg=8, rf_write_data=0xDEADBEEF in cycle N+1; mdu_ready stays 1.
- MDU during idle WB: mdu result to reg 9 with 0x12345678, wb_valid=0 → fifo_count=1 the next cycle, then dequeued, with rf write to reg 9 one cycle after grant; mdu_pending[9] is high exactly while the entry is queued.
- Full/back-pressure: wb_valid=1 continuously, offer 3 MDU results → first 2 accepted, mdu_ready=0 after the second. When wb_valid drops, writes retire in order (first, second), then the third is accepted.
- Starvation: FIFO non-empty with wb_valid=1 for 4 cycles (STARVE_MAX=4) → wb_stall_req=1. Drop wb_valid one cycle → head retires and wb_stall_req=0 the following cycle.
- REGFILE_ZERO_FILTER_EN: WB write to reg 0 with data 0x5 → rf_reg_write stays 0. Without the macro → rf_reg_write=1, rf_write_reg=0.
